if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS core. It sits directly upstream of the control decoder.
- Owns the PC and issues word fetches to instruction memory over a req/ready handshake.
- Holds the fetched instruction in an instruction register (IR) and presents op/funct to the decoder.
- Applies branch/jump redirects returned by the execute logic for the instruction currently in IR.

Parameters:
- RESET_PC, 32'h0000_3000: address of the first fetch after reset; must be word aligned.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  downstream cannot accept the IR contents this cycle
- branch_taken  in  1  the IR instruction is a branch whose condition holds
- branch_imm  in  16  imm16 of the IR branch
- jump  in  1  the IR instruction is J
- jump_index  in  26  instr_index of the IR jump
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched word
- ir  out  32  held instruction
- ir_pc  out  32  address of ir
- ir_valid  out  1  ir holds a live instruction
- op  out  6  ir[31:26], driven to the decoder
- funct  out  6  ir[5:0], driven to the decoder

Behaviour:
- Reset (async, while rst_n=0): fetch_pc=RESET_PC; ir=0; ir_pc=0; ir_valid=0; state=IDLE. Combinationally imem_req=0, imem_addr=RESET_PC, op=0, funct=0.
- States:
  - IDLE: one cycle after reset release, no request, then RUN.
  - RUN: normal fetch.
  - SLOT_WAIT: exists only with IF_DELAY_SLOT_EN.
- imem_addr = fetch_pc at all times.
- accept = ir_valid & ~stall.
- Fetch request: imem_req = (state≠IDLE) & (~ir_valid | ~stall). This is combinational on stall by design.
- Transfer = imem_req & imem_ready; rdata is valid in the same cycle.
- Memory is stateless: req may drop before ready with no side effects.
- On a transfer (no redirect): ir<=imem_rdata, ir_pc<=fetch_pc, ir_valid<=1, fetch_pc<=fetch_pc+4.
- On accept with no transfer: ir_valid<=0.
- Neither accept nor transfer: IR holds.
- Throughput: one instruction per cycle with imem_ready tied high.
- Latency: first transfer in the 2nd cycle after rst_n rises.
- Redirect:
  - Sampled only on accept while branch_taken|jump; ignored when ~accept, even if asserted.
  - Branch target = ir_pc+4+(sext(branch_imm)<<2).
  - Jump target = {ir_pc+4 [31:28], jump_index, 2'b00}.
  - Addition is modulo 2^32; wrap-around is legal. Jump has priority if both are asserted.
  - Redirect cycle: fetch_pc<=target. Any same-cycle transfer (the word at ir_pc+4) is discarded, so ir_valid<=0.
  - The next transfer is from the target.
- imem_addr[1:0] is always 2'b00.
- Reset mid-fetch or mid-redirect: everything clears immediately and any pending target is lost.

Optional Feature:
- Macro: IF_DELAY_SLOT_EN (MIPS branch delay slot).
- Without the macro: as above; the word after a branch/jump is squashed.
- With the macro: on a redirect cycle the target is latched in slot_target and the delay slot is delivered.
  - If a same-cycle transfer (word at ir_pc+4) occurs, it loads IR normally and fetch_pc<=slot_target.
  - Otherwise state->SLOT_WAIT: fetch continues at ir_pc+4. Its transfer loads IR, fetch_pc<=slot_target, state->RUN.
  - A redirect is never sampled for the delay-slot instruction itself; such a branch has architecturally undefined behaviour and is ignored.

Decomposition:
- Package mips_pkg holds:
  - opcode/funct constants
  - field slice positions (OP 31:26, FUNCT 5:0, IMM 15:0, INDEX 25:0)
  - RESET_PC default
  - the fetch-state enum (IDLE, RUN, SLOT_WAIT)
- One combinational sub-module, npc: inputs ir_pc, branch_imm, jump_index, branch_taken, jump; outputs redirect and target.

Test Plan:
- Reset, imem_ready=1, memory returns word=addr -> first imem_req the cycle after IDLE at 0x3000; ir_pc sequence 0x3000, 0x3004, 0x3008 on consecutive cycles; op/funct track ir.
- stall=1 for 3 cycles with ir_valid=1 -> ir/ir_pc frozen, imem_req=0, fetch_pc unchanged; on release the next instruction appears one cycle later.
- Branch at ir_pc=0x3008, branch_imm=16'hFFFE, branch_taken=1 on accept -> no valid 0x300C; next ir_pc=0x3004. With IF_DELAY_SLOT_EN: 0x300C is delivered, then 0x3004.
- Jump at ir_pc=0x3010, jump_index=26'h0000C40 -> next ir_pc=0x0000_3100.
- imem_ready=0 for 2 cycles -> imem_addr stable, ir_valid drops after accept, resumes on ready. With the macro and a redirect during this wait: SLOT_WAIT is entered and the slot is delivered before the target.
- rst_n pulsed low mid-fetch, including in SLOT_WAIT -> ir_valid=0, imem_addr=0x3000 immediately; no stale target fetched afterward.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS definitions for the fetch stage and the control decoder.
// Contents:
//   - opcode (OP_*) and R-type function (FN_*) constants
//   - instruction field slice positions (OP, FUNCT, IMM, INDEX)
//   - RESET_PC_DEFAULT, the address of the first fetch after reset
//   - fetch_state_t, the fetch FSM state encoding
//   - branch_offset(), the sign-extended and word-scaled branch displacement
package mips_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int INDEX_MSB = 25;
  localparam int INDEX_LSB = 0;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  typedef enum logic [1:0] {IDLE, RUN, SLOT_WAIT} fetch_state_t;
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction
endpackage

// File: rtl/npc.sv
// npc: next-PC computation for the instruction held in IR (purely combinational).
// Ports:
//   i_ir_pc        address of the IR instruction
//   i_branch_imm   imm16 of the IR branch
//   i_jump_index   instr_index of the IR jump
//   i_branch_taken branch condition holds
//   i_jump         IR instruction is J
//   o_redirect     a control transfer is requested
//   o_target       redirect address; jump wins over branch when both are set
module npc
  import mips_pkg::*;
(
  input  logic [31:0] i_ir_pc,
  input  logic [15:0] i_branch_imm,
  input  logic [25:0] i_jump_index,
  input  logic        i_branch_taken,
  input  logic        i_jump,
  output logic        o_redirect,
  output logic [31:0] o_target
);
  logic [31:0] w_seq_pc;
  assign w_seq_pc   = i_ir_pc + 32'd4;
  assign o_redirect = i_branch_taken | i_jump;
  assign o_target   = i_jump ? {w_seq_pc[31:28], i_jump_index, 2'b00}
                             : w_seq_pc + branch_offset(i_branch_imm);
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch stage; owns the PC, fetches words and holds them in IR.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   stall                       downstream cannot take IR this cycle
//   branch_taken, branch_imm    taken branch for the IR instruction and its imm16
//   jump, jump_index            J for the IR instruction and its instr_index
//   imem_req, imem_addr         fetch request and word-aligned address
//   imem_ready, imem_rdata      memory returns imem_rdata this cycle
//   ir, ir_pc, ir_valid         held instruction, its address, and liveness
//   op, funct                   ir[31:26] and ir[5:0] for the decoder
// Build option: IF_DELAY_SLOT_EN delivers the branch delay slot instead of squashing it.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  output logic [5:0]  op,
  output logic [5:0]  funct
);
  fetch_state_t r_state, w_next_state;
  logic [31:0] r_fetch_pc, r_ir, r_ir_pc, w_target;
  logic r_ir_valid, w_accept, w_xfer, w_npc_redirect, w_redirect;

  npc u_npc (
    .i_ir_pc        (r_ir_pc),
    .i_branch_imm   (branch_imm),
    .i_jump_index   (jump_index),
    .i_branch_taken (branch_taken),
    .i_jump         (jump),
    .o_redirect     (w_npc_redirect),
    .o_target       (w_target)
  );

  assign w_accept = r_ir_valid & ~stall;
  assign w_xfer   = imem_req & imem_ready;

`ifdef IF_DELAY_SLOT_EN
  logic r_ir_is_slot;
  logic [31:0] r_slot_target;
  // A branch sitting in a delay slot is undefined; it is simply not honoured.
  assign w_redirect = w_accept & w_npc_redirect & ~r_ir_is_slot;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ir_is_slot  <= 1'b0;
      r_slot_target <= '0;
    end else begin
      if (w_xfer) r_ir_is_slot <= w_redirect | (r_state == SLOT_WAIT);
      if (w_redirect) r_slot_target <= w_target;
    end
  always_comb
    w_next_state = (r_state == IDLE) ? RUN :
                   (r_state == RUN) ? ((w_redirect & ~w_xfer) ? SLOT_WAIT : RUN) :
                   (w_xfer ? RUN : SLOT_WAIT);
  // The word fetched alongside (or after) the redirect is the delay slot: keep it,
  // then continue from the latched target.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else if (w_xfer) begin
      r_ir       <= imem_rdata;
      r_ir_pc    <= r_fetch_pc;
      r_ir_valid <= 1'b1;
      r_fetch_pc <= w_redirect ? w_target :
                    (r_state == SLOT_WAIT) ? r_slot_target : r_fetch_pc + 32'd4;
    end else if (w_accept) begin
      r_ir_valid <= 1'b0;
    end
`else
  assign w_redirect = w_accept & w_npc_redirect;
  always_comb w_next_state = RUN;
  // A redirect squashes whatever word arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
      r_ir_valid <= 1'b0;
    end else if (w_xfer) begin
      r_ir       <= imem_rdata;
      r_ir_pc    <= r_fetch_pc;
      r_ir_valid <= 1'b1;
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end else if (w_accept) begin
      r_ir_valid <= 1'b0;
    end
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next_state;

  // Request depends combinationally on stall so a draining IR can refill the same cycle.
  always_comb imem_req = (r_state != IDLE) & (~r_ir_valid | ~stall);

  assign imem_addr = r_fetch_pc;
  assign ir        = r_ir;
  assign ir_pc     = r_ir_pc;
  assign ir_valid  = r_ir_valid;
  assign op        = r_ir[OP_MSB:OP_LSB];
  assign funct     = r_ir[FUNCT_MSB:FUNCT_LSB];
endmodule
